ifetch: RTL and testbench

Instruction fetch unit feeding the ID stage of the pipeline. It generates halfword-aligned fetch addresses, runs a request/acknowledge handshake to instruction memory, and buffers returned 16-bit instructions in a small prefetch queue. It presents one instruction per cycle to ID while honouring the ID stall. On a taken branch from EX it flushes and redirects.

---
 rtl/ifetch_if.sv | 13 +
 rtl/ifetch.sv | 173 +++++++++++++++++
 tb/tb_ifetch.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// Instruction-memory fetch bus between ifetch (master) and instruction memory (slave).
// req/addr are held by the master until the cycle ack is high; data is valid with ack.
interface ifetch_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [15:0]       data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit: issues halfword-aligned fetches, buffers returned
// instructions in a small prefetch queue and feeds one per cycle to ID.
// Optional feature macro: IFETCH_BYPASS_EN (ack data goes straight into the
// ID register when the queue is empty and ID is not stalled).
//
// state | meaning
// FETCH | normal operation, requests issued while queue + outstanding < DEPTH
// DROP  | branch hit with a request in flight; wait for its ack, discard data
module ifetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall_id,
    input  logic              i_branch_met,
    input  logic [ADDR_W-1:0] i_branch_addr,
    ifetch_if.master          imem,
    output logic [15:0]       o_ir_id,
    output logic [ADDR_W-1:0] o_pc_id,
    output logic              o_ir_valid
);

    localparam int                PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W = PTR_W + 1;
    localparam logic [15:0]       NOP   = 16'hBF00;
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC0   = RESET_PC & ALIGN;

    typedef enum logic {FETCH, DROP} state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  target_q, target_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [15:0]        q_ir [DEPTH];
    logic [ADDR_W-1:0]  q_pc [DEPTH];
    logic               push, pop, flush, bypass, id_upd, done;
    logic [ADDR_W-1:0]  br_tgt;

    assign done      = req_q && imem.ack;
    assign br_tgt    = i_branch_addr & ALIGN;
    assign imem.req  = req_q;
    assign imem.addr = fetch_pc_q;

    // Next-state, request and queue control decode
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        bypass     = 1'b0;
        id_upd     = 1'b0;
        if (i_branch_met) begin
            flush    = 1'b1;
            target_d = br_tgt;
            if (!req_q || imem.ack) begin
                // Flushed queue is empty, so a fresh request may go out at once
                // unless the in-flight one just completed.
                state_d    = FETCH;
                fetch_pc_d = br_tgt;
                req_d      = !req_q;
            end else begin
                state_d = DROP;
            end
        end else begin
            if (!i_stall_id) begin
                id_upd = 1'b1;
                pop    = (count_q != '0);
            end
            case (state_q)
                FETCH: begin
                    if (done) begin
                        fetch_pc_d = fetch_pc_q + ADDR_W'(2);
                        req_d      = 1'b0;
`ifdef IFETCH_BYPASS_EN
                        if (count_q == '0 && !i_stall_id) bypass = 1'b1;
                        else                              push   = 1'b1;
`else
                        push = 1'b1;
`endif
                    end else if (!req_q && count_q < CNT_W'(DEPTH)) begin
                        req_d = 1'b1;
                    end
                end
                DROP: begin
                    if (done) begin
                        state_d    = FETCH;
                        fetch_pc_d = target_q;
                        req_d      = 1'b0;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= FETCH;
        else      state_q <= state_d;
    end

    // Fetch address, request and latched branch target
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q      <= 1'b0;
            fetch_pc_q <= PC0;
            target_q   <= PC0;
        end else begin
            req_q      <= req_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
        end
    end

    // Prefetch queue pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Prefetch queue storage, entry = {pc, instruction}
    always_ff @(posedge clk) begin
        if (push) begin
            q_ir[wr_ptr_q] <= imem.data;
            q_pc[wr_ptr_q] <= fetch_pc_q;
        end
    end

    // ID-stage instruction register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_ir_id    <= NOP;
            o_pc_id    <= PC0;
            o_ir_valid <= 1'b0;
        end else if (flush) begin
            o_ir_id    <= NOP;
            o_ir_valid <= 1'b0;
        end else if (bypass) begin
            o_ir_id    <= imem.data;
            o_pc_id    <= fetch_pc_q;
            o_ir_valid <= 1'b1;
        end else if (id_upd) begin
            if (pop) begin
                o_ir_id    <= q_ir[rd_ptr_q];
                o_pc_id    <= q_pc[rd_ptr_q];
                o_ir_valid <= 1'b1;
            end else begin
                o_ir_id    <= NOP;
                o_ir_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch against a queue-based reference model.
module tb_ifetch;
    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 2;
    localparam logic [15:0] NOP    = 16'hBF00;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_stall_id = 1'b0;
    logic              i_branch_met = 1'b0;
    logic [ADDR_W-1:0] i_branch_addr = '0;
    logic [15:0]       o_ir_id;
    logic [ADDR_W-1:0] o_pc_id;
    logic              o_ir_valid;

    ifetch_if #(.ADDR_W(ADDR_W)) imem ();

    ifetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_stall_id    (i_stall_id),
        .i_branch_met  (i_branch_met),
        .i_branch_addr (i_branch_addr),
        .imem          (imem),
        .o_ir_id       (o_ir_id),
        .o_pc_id       (o_pc_id),
        .o_ir_valid    (o_ir_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic                     m_req, m_drop, m_valid;
    logic [ADDR_W-1:0]        m_addr, m_target, m_pc;
    logic [15:0]              m_ir;
    logic [ADDR_W+15:0]       m_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_drop = 0; m_valid = 0;
        m_addr = '0; m_target = '0; m_pc = '0; m_ir = NOP;
        m_q.delete();
    endtask

    task automatic check_all();
        chk("req",   64'(imem.req),   64'(m_req));
        chk("addr",  64'(imem.addr),  64'(m_addr));
        chk("ir",    64'(o_ir_id),    64'(m_ir));
        chk("pc",    64'(o_pc_id),    64'(m_pc));
        chk("valid", 64'(o_ir_valid), 64'(m_valid));
    endtask

    // One clock: drive inputs at negedge, advance model, check after posedge.
    task automatic cycle(input logic stall, input logic br, input logic [ADDR_W-1:0] tgt,
                         input logic ack_en);
        logic              ack, done, byp;
        logic [15:0]       data;
        int                sz0;
        logic [ADDR_W+15:0] e;
        @(negedge clk);
        ack  = ack_en && m_req;
        data = 16'($urandom);
        i_stall_id    = stall;
        i_branch_met  = br;
        i_branch_addr = tgt;
        imem.ack      = ack;
        imem.data     = data;
        done = m_req && ack;
        sz0  = m_q.size();
        if (br) begin
            m_q.delete();
            m_ir = NOP; m_valid = 0;
            if (!m_req) begin
                m_drop = 0; m_addr = tgt & ~32'h1; m_req = 1;
            end else if (ack) begin
                m_drop = 0; m_addr = tgt & ~32'h1; m_req = 0;
            end else begin
                m_drop = 1; m_target = tgt & ~32'h1;
            end
        end else begin
            byp = 0;
`ifdef IFETCH_BYPASS_EN
            byp = done && !m_drop && sz0 == 0 && !stall;
`endif
            if (!stall) begin
                if (byp) begin
                    m_ir = data; m_pc = m_addr; m_valid = 1;
                end else if (m_q.size() > 0) begin
                    e = m_q.pop_front();
                    m_ir = e[15:0]; m_pc = e[ADDR_W+15:16]; m_valid = 1;
                end else begin
                    m_ir = NOP; m_valid = 0;
                end
            end
            if (done && !m_drop && !byp) m_q.push_back({m_addr, data});
            if (done) begin
                m_req = 0;
                if (m_drop) begin
                    m_drop = 0; m_addr = m_target;
                end else begin
                    m_addr = m_addr + 2;
                end
            end else if (!m_req && !m_drop && sz0 < DEPTH) begin
                m_req = 1;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int k;
        imem.ack  = 1'b0;
        imem.data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all();

        // Sequential fetch, memory acks every request
        for (int i = 0; i < 24; i++) cycle(0, 0, '0, 1);

        // ID stalled: queue fills to DEPTH, req drops; then drains in order
        for (int i = 0; i < 5; i++) cycle(1, 0, '0, 1);
        chk("queue_full_cnt", 64'(dut.count_q), 64'(DEPTH));
        chk("req_low_full", 64'(imem.req), 64'(0));
        for (int i = 0; i < 8; i++) cycle(0, 0, '0, 1);

        // Branch with no outstanding request
        k = 0;
        while (m_req && k < 20) begin cycle(0, 0, '0, 1); k++; end
        cycle(0, 1, 32'h0000_0101, 0);
        chk("br_addr_align", 64'(imem.addr), 64'(32'h0000_0100));
        chk("br_bubble", 64'(o_ir_valid), 64'(0));
        for (int i = 0; i < 6; i++) cycle(0, 0, '0, 1);

        // Branch while request outstanding, ack three cycles later
        k = 0;
        while (!m_req && k < 20) begin cycle(0, 0, '0, 0); k++; end
        cycle(0, 1, 32'h0000_2000, 0);
        cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1);
        chk("drop_redirect", 64'(o_pc_id), 64'(32'h0000_2000));

        // Branch and ack in the same cycle while ID is stalled
        k = 0;
        while (!m_req && k < 20) begin cycle(0, 0, '0, 0); k++; end
        cycle(1, 1, 32'h0000_3000, 1);
        chk("brack_bubble", 64'(o_ir_valid), 64'(0));
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1);

        // Address wrap at top of space
        k = 0;
        while (m_req && k < 20) begin cycle(0, 0, '0, 1); k++; end
        cycle(0, 1, 32'hFFFF_FFFE, 0);
        cycle(0, 0, '0, 1);
        chk("wrap_addr", 64'(imem.addr), 64'(0));
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                  $urandom, ($urandom_range(0, 2) != 0));

        // Reset asserted mid-request
        k = 0;
        while (!m_req && k < 20) begin cycle(0, 0, '0, 0); k++; end
        @(negedge clk);
        imem.ack = 1'b1;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_req", 64'(imem.req), 64'(0));
        chk("rst_addr", 64'(imem.addr), 64'(0));
        chk("rst_ir", 64'(o_ir_id), 64'(NOP));
        chk("rst_valid", 64'(o_ir_valid), 64'(0));
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        imem.ack = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) cycle(0, 0, '0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
